// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for lock with timeout
// and bounded retries, qualifies lock stability, then releases the system
// reset. Lock loss in RUN re-sequences. Status/control via Avalon-MM slave.
module pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 10,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        sys_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata
);

    localparam int unsigned RST_W = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;

    typedef enum logic [2:0] {
        ST_RESET_PLL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic [7:0]         lol_cnt_q, lol_cnt_d;
    logic               sync1_q;
    logic               locked_s_q;
    logic               pll_rst_q;
    logic               sys_reset_n_q;
    logic [31:0]        readdata_q, readdata_d;

    logic               restart_c;
    logic               clr_lol_c;
    logic               attempt_fail_c;
    logic [31:0]        status_c;
    logic               wdata_unused_c;

    // Control-register strobes decoded from the current bus write
    assign restart_c      = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[0];
    assign clr_lol_c      = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[1];
    assign wdata_unused_c = ^avs_writedata[31:2];

    // STATUS register image
    assign status_c = {8'd0, lol_cnt_q, 4'd0, retry_q, 1'b0, 3'(state_q), 1'b0,
                       locked_s_q, (state_q == ST_FAIL), (state_q == ST_RUN)};

    // Next-state, counter and read-data decode; restart overrides every event
    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        to_cnt_d       = to_cnt_q;
        stb_cnt_d      = stb_cnt_q;
        retry_d        = retry_q;
        lol_cnt_d      = lol_cnt_q;
        attempt_fail_c = 1'b0;
        readdata_d     = 32'd0;

        case (state_q)
            ST_RESET_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = ST_WAIT_LOCK;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d   = ST_STABLE_CHK;
                    stb_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    attempt_fail_c = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_STABLE_CHK: begin
                if (!locked_s_q) begin
                    attempt_fail_c = 1'b1;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    lol_cnt_d = (lol_cnt_q == 8'hFF) ? lol_cnt_q : lol_cnt_q + 8'd1;
                    retry_d   = 4'd0;
                    state_d   = ST_RESET_PLL;
                    rst_cnt_d = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d   = ST_RESET_PLL;
                rst_cnt_d = '0;
            end
        endcase

        // Failed attempt: retry while budget remains, otherwise park in FAIL
        if (attempt_fail_c) begin
            if (retry_q < RETRY_MAX) begin
                retry_d   = retry_q + 4'd1;
                state_d   = ST_RESET_PLL;
                rst_cnt_d = '0;
            end else begin
                state_d = ST_FAIL;
            end
        end

        if (clr_lol_c) begin
            lol_cnt_d = 8'd0;
        end

        // Software restart: lol_count keeps its old value unless cleared
        if (restart_c) begin
            state_d   = ST_RESET_PLL;
            rst_cnt_d = '0;
            retry_d   = 4'd0;
            lol_cnt_d = clr_lol_c ? 8'd0 : lol_cnt_q;
        end

        if (avs_read && (avs_address == ADDR_STATUS)) begin
            readdata_d = status_c;
        end
    end

    // State, counters, lock synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            rst_cnt_q     <= '0;
            to_cnt_q      <= '0;
            stb_cnt_q     <= '0;
            retry_q       <= 4'd0;
            lol_cnt_q     <= 8'd0;
            sync1_q       <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            readdata_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            to_cnt_q      <= to_cnt_d;
            stb_cnt_q     <= stb_cnt_d;
            retry_q       <= retry_d;
            lol_cnt_q     <= lol_cnt_d;
            sync1_q       <= pll_locked;
            locked_s_q    <= sync1_q;
            pll_rst_q     <= (state_d == ST_RESET_PLL);
            sys_reset_n_q <= (state_d == ST_RUN);
            readdata_q    <= readdata_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset_n  = sys_reset_n_q;
    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: phase/timestamp model checked every cycle,
// plus directed scenarios with hand-computed latencies and STATUS values.
module tb_pll_lock_sequencer;

    localparam int P_RST  = 4;
    localparam int P_TO   = 20;
    localparam int P_STB  = 8;
    localparam int P_MAXR = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic        pll_rst;
    logic        sys_reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .LOCK_STABLE_CYCLES (P_STB),
        .MAX_RETRIES        (P_MAXR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_reset_n  (sys_reset_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each phase remembers the edge it was entered on; dwell times are
    // differences of edge numbers. The lock pin history gives locked_s.
    typedef enum int {M_PULSE, M_WAIT, M_QUAL, M_RUN, M_DEAD} mphase_t;

    mphase_t     ph = M_PULSE;
    mphase_t     m_nx;
    int unsigned cyc = 0;
    int unsigned ph_start = 0;
    int unsigned m_in;
    int          m_retry = 0;
    int          m_lol = 0;
    bit          m_valid = 1'b0;
    bit          m_ls, m_restart, m_clr, m_failed;
    logic [31:0] m_rd = 32'd0;
    bit          lq[$];

    function automatic int ph_code(input mphase_t p);
        case (p)
            M_PULSE: return 0;
            M_WAIT:  return 1;
            M_QUAL:  return 2;
            M_RUN:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_status(input bit ls);
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (ph == M_RUN);
        s[1]     = (ph == M_DEAD);
        s[2]     = ls;
        s[6:4]   = 3'(ph_code(ph));
        s[11:8]  = 4'(m_retry);
        s[23:16] = 8'(m_lol);
        return s;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_valid = 1'b1;
        if (!reset_n) begin
            ph       = M_PULSE;
            ph_start = cyc;
            m_retry  = 0;
            m_lol    = 0;
            m_rd     = 32'd0;
            lq.delete();
        end else begin
            m_ls      = (lq.size() >= 2) ? lq[lq.size()-2] : 1'b0;
            m_rd      = (avs_read && avs_address == 2'd0) ? m_status(m_ls) : 32'd0;
            m_restart = avs_write && avs_address == 2'd1 && avs_writedata[0];
            m_clr     = avs_write && avs_address == 2'd1 && avs_writedata[1];
            m_in      = cyc - ph_start;
            m_failed  = 1'b0;
            m_nx      = ph;
            case (ph)
                M_PULSE: if (m_in >= P_RST) m_nx = M_WAIT;
                M_WAIT:  begin
                    if (m_ls) m_nx = M_QUAL;
                    else if (m_in >= P_TO) m_failed = 1'b1;
                end
                M_QUAL:  begin
                    if (!m_ls) m_failed = 1'b1;
                    else if (m_in >= P_STB) m_nx = M_RUN;
                end
                M_RUN:   begin
                    if (!m_ls && !m_restart) begin
                        m_lol   = (m_lol < 255) ? m_lol + 1 : 255;
                        m_retry = 0;
                        m_nx    = M_PULSE;
                    end
                end
                default: ;
            endcase
            if (m_failed) begin
                if (m_retry < P_MAXR) begin
                    m_retry++;
                    m_nx = M_PULSE;
                end else begin
                    m_nx = M_DEAD;
                end
            end
            if (m_clr) m_lol = 0;
            if (m_restart) begin
                m_nx    = M_PULSE;
                m_retry = 0;
            end
            if (m_restart || m_nx != ph) ph_start = cyc;
            ph = m_nx;
            lq.push_back(pll_locked);
            if (lq.size() > 4) void'(lq.pop_front());
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_pll_rst", 32'(pll_rst), 32'(ph == M_PULSE));
            check("cyc_sys_reset_n", 32'(sys_reset_n), 32'(ph == M_RUN));
            check("cyc_readdata", avs_readdata, m_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic sig(input int which);
        return (which == 0) ? pll_rst : sys_reset_n;
    endfunction

    task automatic wait_sig(input int which, input logic val, input int max,
                            input string nm, output int n);
        n = 0;
        while (sig(which) !== val) begin
            if (n >= max) begin
                checks++;
                failures++;
                $display("FAIL %s: timeout after %0d cycles, got %b expected %b",
                         nm, n, sig(which), val);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        avs_read    = 1'b1;
        avs_address = a;
        @(negedge clk);
        avs_read    = 1'b0;
        avs_address = 2'd0;
        d = avs_readdata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] wd);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = wd;
        @(negedge clk);
        avs_write     = 1'b0;
        avs_address   = 2'd0;
        avs_writedata = 32'd0;
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n;
        int          hi;
        int          mism;
        logic [31:0] d;
        bit          exp_hi;

        reset_n       = 1'b0;
        pll_locked    = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_pll_rst", 32'(pll_rst), 32'd1);
        check("reset_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check("reset_readdata", avs_readdata, 32'd0);

        // Normal lock
        reset_n = 1'b1;
        pulse_len(n);
        check("first_pulse_len", n, 4);
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        wait_sig(1, 1'b1, 100, "lock_release", n);
        check("lock_to_release", n, 11);
        do_read(2'd0, d);
        check("status_run", d, 32'h0000_0035);   // running | locked_s | state 3

        // Lock loss in RUN, re-lock, then clear lol_count
        pll_locked = 1'b0;
        wait_sig(1, 1'b0, 20, "lol_drop", n);
        check("lol_drop_latency", n, 3);
        check("lol_pll_rst", 32'(pll_rst), 32'd1);
        do_read(2'd0, d);
        check("status_after_lol", d, 32'h0001_0000);
        pll_locked = 1'b1;
        wait_sig(1, 1'b1, 100, "relock", n);
        do_read(2'd0, d);
        check("status_relocked", d, 32'h0001_0035);
        do_write(2'd1, 32'h2);
        do_read(2'd0, d);
        check("status_lol_cleared", d, 32'h0000_0035);

        // Stability glitch: 5 cycles of lock is short of the 8 needed
        pll_locked = 1'b0;
        do_write(2'd1, 32'h1);
        wait_sig(0, 1'b0, 20, "glitch_pulse_end", n);
        pll_locked = 1'b1;
        hi = 0;
        repeat (5) begin
            @(negedge clk);
            if (sys_reset_n !== 1'b0) hi++;
        end
        pll_locked = 1'b0;
        n = 0;
        while (pll_rst !== 1'b1 && n < 40) begin
            if (sys_reset_n !== 1'b0) hi++;
            @(negedge clk);
            n++;
        end
        check("glitch_new_pulse", 32'(pll_rst), 32'd1);
        check("glitch_sys_low", hi, 0);
        do_read(2'd0, d);
        check("status_glitch", d, 32'h0000_0100);

        // Never lock: three pulses 20 cycles apart, then FAIL
        do_write(2'd1, 32'h1);
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            exp_hi = (i < 4) || (i >= 24 && i < 28) || (i >= 48 && i < 52);
            if (pll_rst !== exp_hi) mism++;
            @(negedge clk);
        end
        check("never_lock_trace", mism, 0);
        do_read(2'd0, d);
        check("status_fail", d, 32'h0000_0242);
        check("model_status_fail", m_rd, 32'h0000_0242);
        hi = 0;
        repeat (1000) begin
            @(negedge clk);
            if (sys_reset_n !== 1'b0 || pll_rst !== 1'b0) hi++;
        end
        check("fail_outputs_held", hi, 0);

        // Software restart out of FAIL
        do_write(2'd1, 32'h1);
        check("restart_pll_rst", 32'(pll_rst), 32'd1);
        do_read(2'd0, d);
        check("status_restart", d, 32'h0000_0000);

        // Restart coincident with locked_s falling in RUN: no lol increment
        pll_locked = 1'b1;
        wait_sig(1, 1'b1, 100, "run_again", n);
        pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_write(2'd1, 32'h1);
        check("coincident_pll_rst", 32'(pll_rst), 32'd1);
        do_read(2'd0, d);
        check("status_coincident", d, 32'h0000_0000);

        // Mid-operation reset during stability check
        wait_sig(0, 1'b0, 20, "pulse_end2", n);
        pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        reset_n     = 1'b0;
        avs_read    = 1'b1;
        avs_address = 2'd0;
        @(negedge clk);
        check("midrst_pll_rst", 32'(pll_rst), 32'd1);
        check("midrst_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check("midrst_readdata", avs_readdata, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        avs_read = 1'b0;
        pulse_len(n);
        check("midrst_pulse_len", n, 4);
        wait_sig(1, 1'b1, 100, "final_release", n);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
